// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: acknowledges receiver frames, masks unused data bits
// and captures words into a show-ahead RX FIFO with RTS, overrun and IRQ status.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx_done,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_done_clr,
  input  logic [1:0]                    cfg_data_bit_num,
  input  logic                          rx_enable,
  input  logic                          irq_en,
  input  logic                          fifo_pop,
  input  logic                          fifo_flush,
  input  logic                          clr_overrun,
  output logic [DATA_WIDTH-1:0]         fifo_rdata,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rts_n,
  output logic                          stt_overrun,
  output logic                          irq_rx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);

  typedef enum logic [1:0] {IDLE, CAPT, ACK, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  data_mask;
  logic [3:0]             n_bits;
  logic                   push, pop, overrun_evt;

  assign fifo_empty  = (level_q == '0);
  assign fifo_full   = (level_q == LVL_FULL);
  assign fifo_level  = level_q;
  assign rts_n       = (level_q >= LVL_AF);
  assign stt_overrun = overrun_q;
  assign irq_rx      = irq_en & ~fifo_empty;
  assign fifo_rdata  = fifo_empty ? '0 : mem[rd_ptr_q];
  // Decoded straight from the state register so the receiver sees a clean pulse.
  assign rx_done_clr = (state_q == ACK);

  always_comb begin
    data_mask = '0;
    n_bits    = 4'd5 + {2'b00, cfg_data_bit_num};
    for (int i = 0; i < DATA_WIDTH; i++) data_mask[i] = (i < int'(n_bits));
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    overrun_evt = 1'b0;
    unique case (state_q)
      IDLE: if (rx_done) state_d = CAPT;
      CAPT: begin
        push        = rx_enable & (~fifo_full | fifo_pop);
        overrun_evt = rx_enable & fifo_full & ~fifo_pop;
        state_d     = ACK;
      end
      ACK:  state_d = WAIT;
      WAIT: if (!rx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pop = fifo_pop & ~fifo_empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    if (clr_overrun) overrun_d = 1'b0;
    if (overrun_evt) overrun_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: storage is not reset; the read port is forced to 0 while empty, so stale words never leak.
  always_ff @(posedge clk) begin
    if (push && !fifo_flush) mem[wr_ptr_q] <= rx_data & data_mask;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table for masking/enable plus
// hand-written sequences for fill, overrun, pop-in-capture, flush and reset.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_done, rx_done_clr, rx_enable, irq_en;
  logic [7:0] rx_data, fifo_rdata;
  logic [1:0] cfg_data_bit_num;
  logic       fifo_pop, fifo_flush, clr_overrun;
  logic       fifo_empty, fifo_full, rts_n, stt_overrun, irq_rx;
  logic [3:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q[$];
  logic       exp_ovr = 1'b0;

  uart_rx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_data(rx_data),
    .rx_done_clr(rx_done_clr), .cfg_data_bit_num(cfg_data_bit_num),
    .rx_enable(rx_enable), .irq_en(irq_en), .fifo_pop(fifo_pop),
    .fifo_flush(fifo_flush), .clr_overrun(clr_overrun), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .rts_n(rts_n), .stt_overrun(stt_overrun), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] data;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected word follows the frame config; stored only if enabled and room exists.
  function automatic logic [7:0] mask_of(input logic [1:0] cfg, input logic [7:0] d);
    return d & (8'hFF >> (3 - cfg));
  endfunction

  task automatic sb_frame(input logic [7:0] d, input logic [1:0] cfg, input logic en);
    if (en && sb_q.size() < 8) sb_q.push_back(mask_of(cfg, d));
    else if (en) exp_ovr = 1'b1;
  endtask

  // Full frame handshake; call with the bench sitting just after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] cfg);
    bit seen = 0;
    rx_data = d;
    cfg_data_bit_num = cfg;
    rx_done = 1'b1;
    sb_frame(d, cfg, rx_enable);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (rx_done_clr) seen = 1;
    end
    if (!seen) check("rx_done_clr_timeout", 0, 1);
    next_cycle();
    rx_done = 1'b0;
    next_cycle();
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
    check(name, fifo_rdata, exp);
    fifo_pop = 1'b1;
    next_cycle();
    fifo_pop = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{cfg: 2'b00, data: 8'hFF, en: 1'b1, exp: 8'h1F};
    vecs[1] = '{cfg: 2'b10, data: 8'hFF, en: 1'b1, exp: 8'h7F};
    vecs[2] = '{cfg: 2'b01, data: 8'hFF, en: 1'b1, exp: 8'h3F};
    vecs[3] = '{cfg: 2'b11, data: 8'hFF, en: 1'b1, exp: 8'hFF};
    vecs[4] = '{cfg: 2'b00, data: 8'hA5, en: 1'b1, exp: 8'h05};
    vecs[5] = '{cfg: 2'b01, data: 8'hC3, en: 1'b1, exp: 8'h03};
    vecs[6] = '{cfg: 2'b11, data: 8'h5A, en: 1'b0, exp: 8'h00};

    reset_n = 1'b0; rx_done = 1'b0; rx_data = '0; cfg_data_bit_num = 2'b11;
    rx_enable = 1'b1; irq_en = 1'b1; fifo_pop = 1'b0; fifo_flush = 1'b0; clr_overrun = 1'b0;
    repeat (3) next_cycle();

    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_rdata", fifo_rdata, 0);
    check("rst_rts_n", rts_n, 0);
    check("rst_overrun", stt_overrun, 0);
    check("rst_irq", irq_rx, 0);
    check("rst_clr", rx_done_clr, 0);
    reset_n = 1'b1;
    next_cycle();

    // Single frame with cycle-exact latency.
    rx_data = 8'hA5; cfg_data_bit_num = 2'b11; rx_done = 1'b1;
    sb_frame(8'hA5, 2'b11, 1'b1);
    @(negedge clk); check("lat_c_level", fifo_level, 0); check("lat_c_clr", rx_done_clr, 0);
    @(negedge clk); check("lat_c1_level", fifo_level, 0); check("lat_c1_clr", rx_done_clr, 0);
    @(negedge clk); check("lat_c2_level", fifo_level, 1); check("lat_c2_clr", rx_done_clr, 1);
    check("lat_irq", irq_rx, 1);
    next_cycle(); rx_done = 1'b0;
    @(negedge clk); check("lat_c3_clr", rx_done_clr, 0);
    next_cycle();
    check("single_level", fifo_level, 1);
    pop_check("single_data");
    check("single_empty", fifo_empty, 1);
    check("single_irq_off", irq_rx, 0);

    // Table: masking and rx_enable.
    for (int i = 0; i < 7; i++) begin
      rx_enable = vecs[i].en;
      send_frame(vecs[i].data, vecs[i].cfg);
      check($sformatf("vec%0d_level", i), fifo_level, vecs[i].en ? 1 : 0);
      if (vecs[i].en) check($sformatf("vec%0d_exp", i), fifo_rdata, vecs[i].exp);
      if (sb_q.size() != 0) pop_check($sformatf("vec%0d_sb", i));
      check($sformatf("vec%0d_ovr", i), stt_overrun, 0);
    end
    rx_enable = 1'b1;

    // Fill to full, RTS from level 6, then overrun on the 9th frame.
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'(i), 2'b11);
      check($sformatf("fill%0d_level", i), fifo_level, i);
      check($sformatf("fill%0d_rts", i), rts_n, (i >= 6) ? 1 : 0);
    end
    check("fill_full", fifo_full, 1);
    send_frame(8'h09, 2'b11);
    check("ovr_set", stt_overrun, exp_ovr);
    check("ovr_head", fifo_rdata, 8'h01);
    check("ovr_level", fifo_level, 8);
    clr_overrun = 1'b1; next_cycle(); clr_overrun = 1'b0; exp_ovr = 1'b0;
    check("ovr_clr", stt_overrun, 0);

    // Full FIFO with a pop during CAPT: word stored, no overrun.
    rx_data = 8'h0A; cfg_data_bit_num = 2'b11; rx_done = 1'b1;
    next_cycle();
    check("fp_head", fifo_rdata, sb_q.pop_front());
    fifo_pop = 1'b1;
    next_cycle();
    fifo_pop = 1'b0;
    sb_q.push_back(8'h0A);
    check("fp_clr", rx_done_clr, 1);
    check("fp_level", fifo_level, 8);
    check("fp_ovr", stt_overrun, 0);
    next_cycle(); rx_done = 1'b0; next_cycle();
    for (int i = 0; i < 8; i++) pop_check($sformatf("drain%0d", i));
    check("drain_empty", fifo_empty, 1);
    check("drain_rts", rts_n, 0);

    // Pop when empty is ignored.
    fifo_pop = 1'b1; next_cycle(); fifo_pop = 1'b0;
    check("uf_level", fifo_level, 0);
    check("uf_rdata", fifo_rdata, 0);

    // Flush during CAPT with level 3.
    for (int i = 0; i < 3; i++) send_frame(8'h30 + 8'(i), 2'b11);
    check("fl_pre", fifo_level, 3);
    rx_data = 8'h77; rx_done = 1'b1;
    next_cycle();
    fifo_flush = 1'b1;
    next_cycle();
    fifo_flush = 1'b0;
    sb_q.delete();
    check("fl_level", fifo_level, 0);
    check("fl_clr", rx_done_clr, 1);
    check("fl_ovr", stt_overrun, 0);
    next_cycle(); rx_done = 1'b0; next_cycle();
    check("fl_empty", fifo_empty, 1);

    // Reset asserted in ACK, then exactly one capture with rx_done still high.
    rx_data = 8'h3C; rx_done = 1'b1;
    next_cycle(); next_cycle();
    check("ra_clr_pre", rx_done_clr, 1);
    reset_n = 1'b0;
    #1;
    check("ra_clr", rx_done_clr, 0);
    check("ra_level", fifo_level, 0);
    next_cycle();
    reset_n = 1'b1;
    begin
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rx_done_clr) pulses++;
      end
      check("ra_pulses", pulses, 1);
    end
    check("ra_level_one", fifo_level, 1);
    sb_q.push_back(8'h3C);
    next_cycle(); rx_done = 1'b0; next_cycle();
    pop_check("ra_data");
    check("ra_end_empty", fifo_empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
